// File: rtl/input_conditioner.sv
// Conditions DE1-SoC slide switches and push-buttons: two-flop synchronisers,
// per-bit counter debounce, KEY polarity inversion and registered edge events.
module input_conditioner #(
  parameter int N_SW            = 8,
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic [N_SW-1:0]  sw_raw,
  input  logic [N_BTN-1:0] key_raw,
  output logic [N_SW-1:0]  sw_clean,
  output logic [N_BTN-1:0] btn_clean,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic             sw_change
);

  // Switches occupy the low bits of the combined debounce vector, buttons the high bits.
  localparam int N_ALL = N_SW + N_BTN;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [N_SW-1:0]  sw_sync1_r;
  logic [N_SW-1:0]  sw_sync2_r;
  logic [N_BTN-1:0] key_sync1_r;
  logic [N_BTN-1:0] key_sync2_r;

  logic [N_ALL-1:0] level_s;
  logic [N_ALL-1:0] stable_r;
  logic [N_ALL-1:0] stable_nxt_s;
  logic [CNT_W-1:0] cnt_r     [N_ALL];
  logic [CNT_W-1:0] cnt_nxt_s [N_ALL];

  logic [N_SW-1:0]  sw_cur_s;
  logic [N_SW-1:0]  sw_nxt_s;
  logic [N_BTN-1:0] btn_cur_s;
  logic [N_BTN-1:0] btn_nxt_s;

  logic [N_BTN-1:0] btn_press_r;
  logic [N_BTN-1:0] btn_release_r;
  logic             sw_change_r;

  // Two-flop synchronisers; keys reset to the released (high) level so power-up is quiet.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sw_sync1_r  <= '0;
      sw_sync2_r  <= '0;
      key_sync1_r <= '1;
      key_sync2_r <= '1;
    end else begin
      sw_sync1_r  <= sw_raw;
      sw_sync2_r  <= sw_sync1_r;
      key_sync1_r <= key_raw;
      key_sync2_r <= key_sync1_r;
    end
  end

  assign level_s = {~key_sync2_r, sw_sync2_r};

  // Per-bit debounce next state: any disagreement must persist DEBOUNCE_CYCLES cycles.
  always_comb begin
    stable_nxt_s = stable_r;
    for (int i = 0; i < N_ALL; i++) begin
      cnt_nxt_s[i] = cnt_r[i];
      if (level_s[i] == stable_r[i]) begin
        cnt_nxt_s[i] = '0;
      end else if (cnt_r[i] == CNT_MAX) begin
        stable_nxt_s[i] = level_s[i];
        cnt_nxt_s[i]    = '0;
      end else begin
        cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
      end
    end
  end

  // Debounce state and counters.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      stable_r <= '0;
      for (int i = 0; i < N_ALL; i++) begin
        cnt_r[i] <= '0;
      end
    end else begin
      stable_r <= stable_nxt_s;
      for (int i = 0; i < N_ALL; i++) begin
        cnt_r[i] <= cnt_nxt_s[i];
      end
    end
  end

  assign sw_cur_s  = stable_r[N_SW-1:0];
  assign sw_nxt_s  = stable_nxt_s[N_SW-1:0];
  assign btn_cur_s = stable_r[N_ALL-1:N_SW];
  assign btn_nxt_s = stable_nxt_s[N_ALL-1:N_SW];

  // Event pulses are registered alongside the stable level so they coincide with the change.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      btn_press_r   <= '0;
      btn_release_r <= '0;
      sw_change_r   <= 1'b0;
    end else begin
      btn_press_r   <= btn_nxt_s & ~btn_cur_s;
      btn_release_r <= ~btn_nxt_s & btn_cur_s;
      sw_change_r   <= |(sw_nxt_s ^ sw_cur_s);
    end
  end

  assign sw_clean    = sw_cur_s;
  assign btn_clean   = btn_cur_s;
  assign btn_press   = btn_press_r;
  assign btn_release = btn_release_r;
  assign sw_change   = sw_change_r;

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench for input_conditioner with an 8-cycle debounce window.
module tb_input_conditioner;

  logic       clk_clk;
  logic       reset_reset_n;
  logic [7:0] sw_raw;
  logic [3:0] key_raw;
  logic [7:0] sw_clean;
  logic [3:0] btn_clean;
  logic [3:0] btn_press;
  logic [3:0] btn_release;
  logic       sw_change;

  typedef struct {
    int          cyc;
    logic [31:0] outs;
    string       tag;
  } exp_t;

  exp_t sb_q[$];
  int   cyc     = 0;
  int   n_check = 0;
  int   n_fail  = 0;

  input_conditioner #(
    .N_SW(8), .N_BTN(4), .DEBOUNCE_CYCLES(8), .CNT_W(4)
  ) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
    .sw_raw(sw_raw), .key_raw(key_raw),
    .sw_clean(sw_clean), .btn_clean(btn_clean),
    .btn_press(btn_press), .btn_release(btn_release), .sw_change(sw_change)
  );

  initial clk_clk = 1'b0;
  always #5 clk_clk = ~clk_clk;

  always @(posedge clk_clk) cyc <= cyc + 1;

  function automatic logic [31:0] pack_outs(input logic [7:0] sw, input logic [3:0] btn,
                                            input logic [3:0] pr, input logic [3:0] rl,
                                            input logic ch);
    return {11'd0, sw, btn, pr, rl, ch};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_check++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  // Expected event lands 10 edges after the drive point (first sample edge + 9).
  task automatic push_exp(input string tag, input logic [7:0] sw, input logic [3:0] btn,
                          input logic [3:0] pr, input logic [3:0] rl, input logic ch);
    exp_t e;
    e.cyc  = cyc + 10;
    e.outs = pack_outs(sw, btn, pr, rl, ch);
    e.tag  = tag;
    sb_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_clk);
    #1;
  endtask

  // Any event pulse must match the next scoreboard entry in cycle and full output value.
  always @(negedge clk_clk) begin
    if (reset_reset_n && ((btn_press | btn_release) != 4'd0 || sw_change)) begin
      if (sb_q.size() == 0) begin
        check_eq("unexpected_event",
                 pack_outs(sw_clean, btn_clean, btn_press, btn_release, sw_change), 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check_eq({e.tag, "_cycle"}, cyc, e.cyc);
        check_eq(e.tag, pack_outs(sw_clean, btn_clean, btn_press, btn_release, sw_change),
                 e.outs);
      end
    end
  end

  initial begin
    reset_reset_n = 1'b1;
    key_raw       = 4'hF;
    sw_raw        = 8'h00;
    #2;
    reset_reset_n = 1'b0;
    #1;
    check_eq("reset_immediate",
             pack_outs(sw_clean, btn_clean, btn_press, btn_release, sw_change), 32'd0);
    step(3);
    reset_reset_n = 1'b1;
    step(50);
    check_eq("post_reset_idle",
             pack_outs(sw_clean, btn_clean, btn_press, btn_release, sw_change), 32'd0);

    // Clean press and release of key 0
    key_raw = 4'b1110;
    push_exp("press0", 8'h00, 4'b0001, 4'b0001, 4'b0000, 1'b0);
    step(30);
    check_eq("held0", {28'd0, btn_clean}, 32'h1);
    key_raw = 4'b1111;
    push_exp("release0", 8'h00, 4'b0000, 4'b0000, 4'b0001, 1'b0);
    step(20);

    // Bounce on key 1 is rejected, then a steady 9-cycle low is accepted
    key_raw = 4'b1101; step(5);
    key_raw = 4'b1111; step(1);
    key_raw = 4'b1101; step(5);
    key_raw = 4'b1111; step(20);
    check_eq("bounce1", {28'd0, btn_clean}, 32'h0);
    key_raw = 4'b1101;
    push_exp("press1", 8'h00, 4'b0010, 4'b0010, 4'b0000, 1'b0);
    step(9);
    key_raw = 4'b1111;
    push_exp("release1", 8'h00, 4'b0000, 4'b0000, 4'b0010, 1'b0);
    step(20);

    // Switch bus
    sw_raw = 8'hA5;
    push_exp("sw_a5", 8'hA5, 4'b0000, 4'b0000, 4'b0000, 1'b1);
    step(20);
    sw_raw = 8'h25;
    push_exp("sw_25", 8'h25, 4'b0000, 4'b0000, 4'b0000, 1'b1);
    step(20);
    check_eq("sw_level", {24'd0, sw_clean}, 32'h25);

    // Simultaneous presses, then simultaneous press and release on different bits
    key_raw = 4'b0101;
    push_exp("press1010", 8'h25, 4'b1010, 4'b1010, 4'b0000, 1'b0);
    step(20);
    key_raw = 4'b1111;
    push_exp("release1010", 8'h25, 4'b0000, 4'b0000, 4'b1010, 1'b0);
    step(20);
    key_raw = 4'b1110;
    push_exp("press0b", 8'h25, 4'b0001, 4'b0001, 4'b0000, 1'b0);
    step(20);
    key_raw = 4'b0111;
    push_exp("swap", 8'h25, 4'b1000, 4'b1000, 4'b0001, 1'b0);
    step(20);
    key_raw = 4'b1111;
    push_exp("release3", 8'h25, 4'b0000, 4'b0000, 4'b1000, 1'b0);
    step(20);

    // Reset mid-count on key 2; switches and key are re-accepted together afterwards
    key_raw = 4'b1011;
    step(4);
    #3;
    reset_reset_n = 1'b0;
    #1;
    check_eq("reset_mid",
             pack_outs(sw_clean, btn_clean, btn_press, btn_release, sw_change), 32'd0);
    step(2);
    reset_reset_n = 1'b1;
    push_exp("reaccept", 8'h25, 4'b0100, 4'b0100, 4'b0000, 1'b1);
    step(20);
    check_eq("held2", {28'd0, btn_clean}, 32'h4);
    key_raw = 4'b1111;
    push_exp("release2", 8'h25, 4'b0000, 4'b0000, 4'b0100, 1'b0);
    step(20);

    check_eq("queue_drain", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_check, n_fail);
    $finish;
  end

endmodule
